// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the core's fetch/data requesters, the port arbiter and the shared memory.
// The slave modport is the arbiter's view. The master modport is the core/memory side.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ack;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ack;
    logic          err;
    logic          stall;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        output i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata, err, stall
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        input  i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata, err, stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one variable-latency memory port between instruction fetch and
// data access, with an optional abort timeout. Build macro ARB_STALL_COUNT_EN adds stall_cycles.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
`ifdef ARB_STALL_COUNT_EN
    output logic [31:0]       stall_cycles,
`endif
    mem_port_arbiter_if.slave bus
);

    localparam int            CW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit            TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CW-1:0] CNT_LAST   = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [DW-1:0] ABORT_DATA = DW'({((DW + 31) / 32){32'hDEADBEEF}});

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_BUSY = 2'd1,
        ST_D_BUSY = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          m_req_q, m_req_d;
    logic          m_we_q, m_we_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          i_ack_q, i_ack_d;
    logic          d_ack_q, d_ack_d;
    logic          err_q, err_d;
    logic          last_d_q, last_d_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          i_elig_s, d_elig_s;
    logic          grant_i_s, grant_d_s;
    logic          timeout_hit_s;
    logic          stall_s;

    // A requester whose ack is showing this cycle has already been served.
    assign i_elig_s      = bus.i_req & ~i_ack_q;
    assign d_elig_s      = bus.d_req & ~d_ack_q;
    assign grant_i_s     = i_elig_s & (~d_elig_s | last_d_q);
    assign grant_d_s     = d_elig_s & (~i_elig_s | ~last_d_q);
    assign timeout_hit_s = TIMEOUT_EN && (cnt_q == CNT_LAST);
    assign stall_s       = (bus.i_req & ~i_ack_q) | (bus.d_req & ~d_ack_q);

    // Next-state, grant, completion and abort decisions.
    always_comb begin
        state_d   = state_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        err_d     = 1'b0;
        last_d_d  = last_d_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_i_s) begin
                    state_d   = ST_I_BUSY;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = bus.i_addr;
                    m_wdata_d = {DW{1'b0}};
                    cnt_d     = {CW{1'b0}};
                    last_d_d  = 1'b0;
                end else if (grant_d_s) begin
                    state_d   = ST_D_BUSY;
                    m_req_d   = 1'b1;
                    m_we_d    = bus.d_we;
                    m_addr_d  = bus.d_addr;
                    m_wdata_d = bus.d_wdata;
                    cnt_d     = {CW{1'b0}};
                    last_d_d  = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_I_BUSY, ST_D_BUSY: begin
                // m_ack wins over a timeout landing in the same cycle.
                if (bus.m_ack) begin
                    state_d = ST_IDLE;
                    m_req_d = 1'b0;
                    if (state_q == ST_I_BUSY) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = bus.m_rdata;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!m_we_q) begin
                            d_rdata_d = bus.m_rdata;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                    end
                end else if (timeout_hit_s) begin
                    state_d = ST_IDLE;
                    m_req_d = 1'b0;
                    err_d   = 1'b1;
                    if (state_q == ST_I_BUSY) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = ABORT_DATA;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = ABORT_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1'b1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs. Reset abandons any in-flight memory access without an ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= {AW{1'b0}};
            m_wdata_q <= {DW{1'b0}};
            i_rdata_q <= {DW{1'b0}};
            d_rdata_q <= {DW{1'b0}};
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            err_q     <= 1'b0;
            last_d_q  <= 1'b1;
            cnt_q     <= {CW{1'b0}};
        end else begin
            state_q   <= state_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            err_q     <= err_d;
            last_d_q  <= last_d_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.m_req   = m_req_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.i_ack   = i_ack_q;
    assign bus.d_ack   = d_ack_q;
    assign bus.err     = err_q;
    assign bus.stall   = stall_s;

`ifdef ARB_STALL_COUNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of stalled cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

    mem_port_arbiter_chk u_chk (
        .clk   (clk),
        .reset (reset),
        .i_ack (i_ack_q),
        .d_ack (d_ack_q),
        .err   (err_q),
        .m_req (m_req_q)
    );

endmodule

// Protocol properties of the arbiter outputs.
module mem_port_arbiter_chk (
    input logic clk,
    input logic reset,
    input logic i_ack,
    input logic d_ack,
    input logic err,
    input logic m_req
);
    a_one_ack:      assert property (@(posedge clk) disable iff (reset) !(i_ack && d_ack));
    a_err_with_ack: assert property (@(posedge clk) disable iff (reset) err |-> (i_ack || d_ack));
    a_ack_idle:     assert property (@(posedge clk) disable iff (reset) (i_ack || d_ack) |-> !m_req);
    a_i_ack_pulse:  assert property (@(posedge clk) disable iff (reset) i_ack |=> !i_ack);
    a_d_ack_pulse:  assert property (@(posedge clk) disable iff (reset) d_ack |=> !d_ack);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a memory model answers m_req, and expected
// completions are queued at stimulus time and compared when i_ack/d_ack appear.
module tb_mem_port_arbiter;
    localparam int          AW       = 32;
    localparam int          DW       = 32;
    localparam int          TIMEOUT  = 4;
    localparam logic [31:0] SCRAMBLE = 32'h1357_9BDF;
    localparam logic [31:0] DEAD     = 32'hDEAD_BEEF;

    typedef struct packed {
        logic        port;   // 0 fetch, 1 data
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
`ifdef ARB_STALL_COUNT_EN
    logic [31:0] stall_cycles;
`endif

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (rst),
`ifdef ARB_STALL_COUNT_EN
        .stall_cycles (stall_cycles),
`endif
        .bus          (bus)
    );

    int          n_cmp       = 0;
    int          n_err       = 0;
    exp_t        sb_q[$];
    logic [31:0] exp_d_rdata = 32'd0;
    int          mem_delay   = 1;
    logic        mem_hold    = 1'b0;
    logic        fixed_en    = 1'b0;
    logic [31:0] fixed_data  = 32'd0;
    int          cyc         = 0;
    int          late_ack_at = -1;
    int          mem_age     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Memory model: acks the mem_delay-th cycle of m_req unless held; can inject a stray ack.
    initial begin
        bus.m_ack   = 1'b0;
        bus.m_rdata = 32'd0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.m_ack = 1'b0;
            if (cyc == late_ack_at) begin
                bus.m_ack = 1'b1;
            end else if (bus.m_req && !mem_hold) begin
                mem_age++;
                if (mem_age == mem_delay) begin
                    bus.m_ack   = 1'b1;
                    bus.m_rdata = fixed_en ? fixed_data : (bus.m_addr ^ SCRAMBLE);
                end
            end else if (!bus.m_req) begin
                mem_age = 0;
            end
        end
    end

    // Scoreboard: every completion must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t got;
        exp_t want;
        if (bus.i_ack || bus.d_ack) begin
            got.port  = bus.d_ack;
            got.rdata = bus.d_ack ? bus.d_rdata : bus.i_rdata;
            got.err   = bus.err;
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected_ack", 64'(sb_q.size()), 64'd1);
            end else begin
                want = sb_q.pop_front();
                check_eq("sb_ack", 64'(got), 64'(want));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_m_req"},   64'(bus.m_req),   64'd0);
        check_eq({pfx, "_m_we"},    64'(bus.m_we),    64'd0);
        check_eq({pfx, "_m_addr"},  64'(bus.m_addr),  64'd0);
        check_eq({pfx, "_m_wdata"}, 64'(bus.m_wdata), 64'd0);
        check_eq({pfx, "_acks"},    64'({bus.i_ack, bus.d_ack, bus.err}), 64'd0);
        check_eq({pfx, "_i_rdata"}, 64'(bus.i_rdata), 64'd0);
        check_eq({pfx, "_d_rdata"}, 64'(bus.d_rdata), 64'd0);
    endtask

    task automatic do_access(input logic is_d, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, output int lat, output int mreq_cyc,
                             output logic stall_ok, output logic stall_at_ack,
                             output logic [31:0] seen_addr, output logic [31:0] seen_wdata,
                             output logic seen_we);
        logic done;
        @(negedge clk);
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = addr;
        end
        lat = 0; mreq_cyc = 0; stall_ok = 1'b1; stall_at_ack = 1'b1;
        seen_addr = 32'd0; seen_wdata = 32'd0; seen_we = 1'b0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            lat++;
            if (bus.m_req) begin
                mreq_cyc++;
                seen_addr = bus.m_addr; seen_wdata = bus.m_wdata; seen_we = bus.m_we;
            end
            if (is_d ? bus.d_ack : bus.i_ack) begin
                done = 1'b1;
                stall_at_ack = bus.stall;
            end else if (!bus.stall) begin
                stall_ok = 1'b0;
            end
        end
        check_eq(is_d ? "d_ack_seen" : "i_ack_seen", 64'(done), 64'd1);
        if (is_d) bus.d_req = 1'b0;
        else      bus.i_req = 1'b0;
    endtask

    initial begin
        int          lat, mreq_cyc;
        logic        stall_ok, stall_at_ack, seen_we, gi, gd, first_seen, spurious;
        logic [31:0] seen_addr, seen_wdata, first_addr;

        rst = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = 32'd0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'd0; bus.d_wdata = 32'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;

        // Contention straight after reset: fetch wins because last_grant starts at data.
        mem_delay = 1;
        sb_q.push_back('{1'b0, 32'h0000_0100 ^ SCRAMBLE, 1'b0});
        sb_q.push_back('{1'b1, 32'h0000_0200 ^ SCRAMBLE, 1'b0});
        exp_d_rdata = 32'h0000_0200 ^ SCRAMBLE;
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = 32'h100;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
        gi = 1'b0; gd = 1'b0; first_seen = 1'b0; first_addr = 32'd0;
        for (int c = 0; c < 40 && !(gi && gd); c++) begin
            @(negedge clk);
            if (bus.m_req && !first_seen) begin first_seen = 1'b1; first_addr = bus.m_addr; end
            if (bus.i_ack) begin gi = 1'b1; bus.i_req = 1'b0; end
            if (bus.d_ack) begin gd = 1'b1; bus.d_req = 1'b0; end
        end
        check_eq("t3_both_acked", 64'({gi, gd}), 64'd3);
        check_eq("t3_first_grant_addr", 64'(first_addr), 64'h100);

        // Single fetch, memory answers one cycle after m_req.
        fixed_en = 1'b1; fixed_data = 32'h2008_0005; mem_delay = 1;
        sb_q.push_back('{1'b0, 32'h2008_0005, 1'b0});
        do_access(1'b0, 1'b0, 32'h40, 32'd0, lat, mreq_cyc, stall_ok, stall_at_ack,
                  seen_addr, seen_wdata, seen_we);
        check_eq("t1_latency", 64'(lat), 64'd2);
        check_eq("t1_m_addr", 64'(seen_addr), 64'h40);
        check_eq("t1_m_we", 64'(seen_we), 64'd0);
        check_eq("t1_mreq_cycles", 64'(mreq_cyc), 64'd1);
        fixed_en = 1'b0;

        // Store with a three-cycle memory; d_rdata must keep the previous load value.
        mem_delay = 3;
        sb_q.push_back('{1'b1, exp_d_rdata, 1'b0});
        do_access(1'b1, 1'b1, 32'h54, 32'd7, lat, mreq_cyc, stall_ok, stall_at_ack,
                  seen_addr, seen_wdata, seen_we);
        check_eq("t2_mreq_cycles", 64'(mreq_cyc), 64'd3);
        check_eq("t2_m_we", 64'(seen_we), 64'd1);
        check_eq("t2_m_wdata", 64'(seen_wdata), 64'd7);
        check_eq("t2_m_addr", 64'(seen_addr), 64'h54);
        check_eq("t2_stall_before_ack", 64'(stall_ok), 64'd1);
        check_eq("t2_stall_at_ack", 64'(stall_at_ack), 64'd0);
        check_eq("t2_latency", 64'(lat), 64'd4);

        // Ack on the last cycle before the timeout still completes normally.
        mem_delay = TIMEOUT;
        sb_q.push_back('{1'b1, 32'h0000_0300 ^ SCRAMBLE, 1'b0});
        exp_d_rdata = 32'h0000_0300 ^ SCRAMBLE;
        do_access(1'b1, 1'b0, 32'h300, 32'd0, lat, mreq_cyc, stall_ok, stall_at_ack,
                  seen_addr, seen_wdata, seen_we);
        check_eq("edge_latency", 64'(lat), 64'(TIMEOUT + 1));

        // Load with no memory answer: abort after TIMEOUT cycles, stray ack afterwards ignored.
        mem_hold = 1'b1;
        sb_q.push_back('{1'b1, DEAD, 1'b1});
        exp_d_rdata = DEAD;
        do_access(1'b1, 1'b0, 32'h60, 32'd0, lat, mreq_cyc, stall_ok, stall_at_ack,
                  seen_addr, seen_wdata, seen_we);
        check_eq("t4_mreq_cycles", 64'(mreq_cyc), 64'(TIMEOUT));
        check_eq("t4_latency", 64'(lat), 64'(TIMEOUT + 1));
        late_ack_at = cyc + 1;
        spurious = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.m_req || bus.i_ack || bus.d_ack || bus.err) spurious = 1'b1;
        end
        check_eq("t4_late_ack_ignored", 64'(spurious), 64'd0);
        check_eq("t4_d_rdata_held", 64'(bus.d_rdata), 64'(DEAD));

        // Reset while a data access is outstanding.
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h70;
        repeat (2) @(negedge clk);
        check_eq("t5_busy_mreq", 64'(bus.m_req), 64'd1);
        rst = 1'b1; bus.d_req = 1'b0;
        @(negedge clk);
        check_reset_outputs("t5");
        rst = 1'b0; mem_hold = 1'b0; mem_delay = 1; exp_d_rdata = 32'd0;
        sb_q.push_back('{1'b0, 32'h0000_0080 ^ SCRAMBLE, 1'b0});
        do_access(1'b0, 1'b0, 32'h80, 32'd0, lat, mreq_cyc, stall_ok, stall_at_ack,
                  seen_addr, seen_wdata, seen_we);
        check_eq("t5_refetch_latency", 64'(lat), 64'd2);
        check_eq("t5_refetch_addr", 64'(seen_addr), 64'h80);

`ifdef ARB_STALL_COUNT_EN
        // Two fetches each stalling five cycles (memory answers on the fourth m_req cycle).
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check_eq("t6_stall_cleared", 64'(stall_cycles), 64'd0);
        mem_delay = 4;
        for (int k = 0; k < 2; k++) begin
            sb_q.push_back('{1'b0, (32'h400 + 32'(k)) ^ SCRAMBLE, 1'b0});
            do_access(1'b0, 1'b0, 32'h400 + 32'(k), 32'd0, lat, mreq_cyc, stall_ok,
                      stall_at_ack, seen_addr, seen_wdata, seen_we);
        end
        repeat (2) @(negedge clk);
        check_eq("t6_stall_cycles", 64'(stall_cycles), 64'd10);
`endif

        repeat (3) @(negedge clk);
        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
